mem_stage_ws: RTL and testbench
===============================

Name: mem_stage_ws

Overview:
Parametrised successor to the single-cycle MEM stage of the 5-stage pipeline. It performs data-memory loads and stores with byte, half and word sizes, sign or zero extension, and alignment checking. It supports configurable wait-state latency with a stall handshake to the hazard unit. It owns the MEM/WB pipeline register, with flush, and keeps the existing combinational branch-resolution output pc_src.

Parameters:
DEPTH, 256, data memory depth in 32-bit words; power of two.
LATENCY, 2, wait states per memory access (0..15); 0 gives single-cycle access.
REG_W, 5, register-index width.
WB_W, 2, writeback-control width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  EX/MEM holds a valid instruction
alu_result  in  32  effective address / ALU value
write_data  in  32  store data
write_reg  in  REG_W  destination register
wb_ctrl  in  WB_W  writeback control
mem_read  in  1  load
mem_write  in  1  store
mem_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
branch  in  1  branch instruction
zero  in  1  ALU zero flag
flush  in  1  squash the current MEM instruction
stall  out  1  hold upstream stages (combinational)
pc_src  out  1  branch taken (combinational)
out_valid  out  1  MEM/WB register valid
read_data  out  32  extended load result
alu_result_out  out  32  registered alu_result
write_reg_out  out  REG_W  registered write_reg
wb_ctrl_out  out  WB_W  registered wb_ctrl; forced 0 on bubble or fault
misaligned  out  1  registered alignment-fault flag

Behaviour:
- Single clock domain. rst is synchronous and active-high. Reset takes priority over everything.
- Reset state: FSM in IDLE, wait counter 0. All registered outputs are 0: out_valid, read_data, alu_result_out, write_reg_out, wb_ctrl_out, misaligned.
- Memory array contents are not affected by rst; they are zero-initialised at time 0.
- pc_src = in_valid & branch & zero & ~flush. It is purely combinational, as before.
- access = in_valid & (mem_read | mem_write) & ~misalign & ~flush.
- misalign = (half & addr[0]) | (word & addr[1:0] != 0).
- Word index = alu_result[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
- FSM has two states, IDLE and WAIT, with a wait counter cnt of 4 bits.
  - IDLE with access and LATENCY > 0: stall = 1. Next state WAIT, cnt <= 1.
  - WAIT with cnt < LATENCY: stall = 1, cnt increments.
  - WAIT with cnt == LATENCY: stall = 0. The access commits at this edge and the FSM returns to IDLE.
  - With LATENCY = 0 the FSM never leaves IDLE, stall is never asserted, and the access commits on the edge it is presented.
  - An access therefore occupies LATENCY+1 cycles, with stall high for the first LATENCY of them.
- Upstream holds all inputs stable while stall = 1. The block samples operands only at the commit edge.
- Commit edge behaviour:
  - A store updates only its selected byte lanes. Byte uses lane addr[1:0] with write_data[7:0]. Half uses lanes {addr[1],0} and {addr[1],1} with write_data[15:0]. Word writes all four lanes.
  - A load selects the lane(s) the same way, extends per mem_unsigned, and registers the result into read_data.
  - If mem_read and mem_write are both high, the store is performed and read_data = 0.
- Non-access valid instructions (ALU ops, branches) pass through in 1 cycle with no stall.
- The MEM/WB register loads on every non-stalled edge:
  - out_valid <= in_valid & ~flush.
  - alu_result_out, write_reg_out and wb_ctrl_out load their inputs.
  - read_data loads the load result, or 0 for non-loads.
- While stall = 1, the MEM/WB register loads a bubble: out_valid = 0, wb_ctrl_out = 0.
- Misaligned load or store: no memory access and no stall. On the next edge misaligned = 1, out_valid = 1, wb_ctrl_out = 0, read_data = 0. The misaligned flag clears on the next edge without a fault.
- flush in any state: the MEM/WB register loads a bubble and misaligned = 0. If the FSM is in WAIT, the access is aborted, no store commits, the FSM returns to IDLE, and stall drops in that same cycle.
- rst mid-WAIT: same as flush, and all outputs are cleared.
- A load immediately following a store to the same word returns the newly stored data.

Test Plan:
- LATENCY=2, word store 0x12345678 to addr 0x04, then word load from 0x04 -> stall high exactly 2 cycles per access; 3rd cycle out_valid=1; read_data=0x12345678, alu_result_out=0x04.
- Byte store 0xAB to 0x05, then signed byte load from 0x05 -> 0xFFFFFFAB; unsigned load -> 0x000000AB; word load 0x04 -> 0x1234AB78.
- Half load from 0x06 (signed, word 0x8001xxxx) -> 0xFFFF8001. Half load from 0x05 -> misaligned=1, wb_ctrl_out=0, stall never asserted, memory unchanged.
- branch=1, zero=1, in_valid=1 -> pc_src=1 same cycle; with flush=1 -> pc_src=0, next out_valid=0.
- Store to 0x10 with flush asserted on 2nd wait cycle -> stall drops that cycle, FSM IDLE; later load from 0x10 returns the old value 0x00000000.
- rst asserted mid-WAIT -> next edge all outputs 0, stall=0. LATENCY=0 build: back-to-back load/store never stalls. Address 0x404 with DEPTH=256 aliases to 0x004.

Source files
------------

// File: rtl/mem_stage_ws.sv
`default_nettype none
// ============================================================================
// mem_stage_ws : MEM stage with wait-state data memory and MEM/WB register
// Revision 1.0
// ============================================================================
module mem_stage_ws #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int REG_W   = 5,
    parameter int WB_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      write_data,
    input  logic [REG_W-1:0] write_reg,
    input  logic [WB_W-1:0]  wb_ctrl,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       mem_size,
    input  logic             mem_unsigned,
    input  logic             branch,
    input  logic             zero,
    input  logic             flush,
    output logic             stall,
    output logic             pc_src,
    output logic             out_valid,
    output logic [31:0]      read_data,
    output logic [31:0]      alu_result_out,
    output logic [REG_W-1:0] write_reg_out,
    output logic [WB_W-1:0]  wb_ctrl_out,
    output logic             misaligned
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    logic          is_half;
    logic          is_word;
    logic          misalign;
    logic          mem_op;
    logic          access;
    logic          commit;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [31:0]   cur_word;
    logic [31:0]   shifted;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [31:0]   load_val;
    logic [3:0]    byte_en;
    logic [31:0]   lane_data;
    logic [31:0]   bit_mask;
    logic [31:0]   merged;

    assign pc_src = in_valid & branch & zero & ~flush;

    assign is_half  = (mem_size == 2'b01);
    assign is_word  = mem_size[1];
    assign misalign = (is_half & alu_result[0]) | (is_word & (alu_result[1:0] != 2'b00));
    assign mem_op   = in_valid & (mem_read | mem_write);
    assign access   = mem_op & ~misalign & ~flush;

    // Upper address bits are dropped, so the array aliases every 4*DEPTH bytes.
    assign idx      = alu_result[AW+1:2];
    assign lane     = alu_result[1:0];
    assign cur_word = mem[idx];

    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    stall = access && (LAT != 4'd0);
                WAIT:    stall = access && (cnt < LAT);
                default: stall = 1'b0;
            endcase
        end
    end

    // Operands are only trusted on the edge where the wait window closes.
    assign commit = access & ~stall & ~rst;

    always_comb begin
        byte_en   = 4'b0000;
        lane_data = 32'd0;
        case (mem_size)
            2'b00: begin
                byte_en   = 4'b0001 << lane;
                lane_data = {4{write_data[7:0]}};
            end
            2'b01: begin
                byte_en   = lane[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{write_data[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                lane_data = write_data;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            bit_mask[8*i +: 8] = {8{byte_en[i]}};
        end
        merged = (cur_word & ~bit_mask) | (lane_data & bit_mask);
    end

    always_comb begin
        shifted  = cur_word >> {lane, 3'b000};
        sel_byte = shifted[7:0];
        sel_half = lane[1] ? cur_word[31:16] : cur_word[15:0];
        case (mem_size)
            2'b00:   load_val = mem_unsigned ? {24'd0, sel_byte}
                                             : {{24{sel_byte[7]}}, sel_byte};
            2'b01:   load_val = mem_unsigned ? {16'd0, sel_half}
                                             : {{16{sel_half[15]}}, sel_half};
            default: load_val = cur_word;
        endcase
    end

    // Memory contents survive rst; only the pipeline state is cleared.
    always_ff @(posedge clk) begin
        if (commit && mem_write) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            out_valid      <= 1'b0;
            read_data      <= 32'd0;
            alu_result_out <= 32'd0;
            write_reg_out  <= '0;
            wb_ctrl_out    <= '0;
            misaligned     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && (LAT != 4'd0)) begin
                        state <= WAIT;
                        cnt   <= 4'd1;
                    end
                end
                WAIT: begin
                    if (!access || (cnt == LAT)) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase

            alu_result_out <= alu_result;
            write_reg_out  <= write_reg;

            if (stall || flush) begin
                out_valid   <= 1'b0;
                wb_ctrl_out <= '0;
                read_data   <= 32'd0;
                misaligned  <= 1'b0;
            end else begin
                out_valid   <= in_valid;
                wb_ctrl_out <= (mem_op && misalign) ? '0 : wb_ctrl;
                misaligned  <= mem_op & misalign;
                read_data   <= (commit && mem_read && !mem_write) ? load_val : 32'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ws.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_ws : scoreboard bench for mem_stage_ws (LATENCY=2 and LATENCY=0)
// Revision 1.0
// ============================================================================
module tb_mem_stage_ws;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_read, mem_write, mem_unsigned, branch, zero, flush;
    logic [31:0] alu_result, write_data;
    logic [4:0]  write_reg;
    logic [1:0]  wb_ctrl, mem_size;
    logic        stall, pc_src, out_valid, misaligned;
    logic [31:0] read_data, alu_result_out;
    logic [4:0]  write_reg_out;
    logic [1:0]  wb_ctrl_out;

    logic        in_valid_z, mem_read_z, mem_write_z;
    logic [31:0] alu_result_z, write_data_z;
    logic        stall_z, pc_src_z, out_valid_z, misaligned_z;
    logic [31:0] read_data_z, alu_result_out_z;
    logic [4:0]  write_reg_out_z;
    logic [1:0]  wb_ctrl_out_z;

    always #5 clk = ~clk;

    mem_stage_ws #(.DEPTH(256), .LATENCY(2), .REG_W(5), .WB_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result),
        .write_data(write_data), .write_reg(write_reg), .wb_ctrl(wb_ctrl),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .branch(branch), .zero(zero), .flush(flush),
        .stall(stall), .pc_src(pc_src), .out_valid(out_valid), .read_data(read_data),
        .alu_result_out(alu_result_out), .write_reg_out(write_reg_out),
        .wb_ctrl_out(wb_ctrl_out), .misaligned(misaligned)
    );

    mem_stage_ws #(.DEPTH(256), .LATENCY(0), .REG_W(5), .WB_W(2)) dut_z (
        .clk(clk), .rst(rst), .in_valid(in_valid_z), .alu_result(alu_result_z),
        .write_data(write_data_z), .write_reg(5'd7), .wb_ctrl(2'b01),
        .mem_read(mem_read_z), .mem_write(mem_write_z), .mem_size(2'b10),
        .mem_unsigned(1'b0), .branch(1'b0), .zero(1'b0), .flush(1'b0),
        .stall(stall_z), .pc_src(pc_src_z), .out_valid(out_valid_z), .read_data(read_data_z),
        .alu_result_out(alu_result_out_z), .write_reg_out(write_reg_out_z),
        .wb_ctrl_out(wb_ctrl_out_z), .misaligned(misaligned_z)
    );

    typedef struct {
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [1:0]  wb;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [256];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Every valid MEM/WB output is matched against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("read_data", read_data, e.rd);
                check("alu_result_out", alu_result_out, e.alu);
                check("write_reg_out", {27'd0, write_reg_out}, {27'd0, e.wr});
                check("wb_ctrl_out", {30'd0, wb_ctrl_out}, {30'd0, e.wb});
                check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
            end
        end
    end

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic uns);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = model_mem[a[9:2]];
        b = w[8*a[1:0] +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        if (sz == 2'b00)      return uns ? {24'd0, b} : {{24{b[7]}}, b};
        else if (sz == 2'b01) return uns ? {16'd0, h} : {{16{h[15]}}, h};
        else                  return w;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        logic [31:0] w;
        w = model_mem[a[9:2]];
        if (sz == 2'b00)      w[8*a[1:0] +: 8] = d[7:0];
        else if (sz == 2'b01) w[16*a[1] +: 16] = d[15:0];
        else                  w = d;
        model_mem[a[9:2]] = w;
    endtask

    task automatic clear_inputs();
        in_valid = 0; mem_read = 0; mem_write = 0; branch = 0; zero = 0; flush = 0;
    endtask

    // Issue one memory op at posedge+1 and hold it until the commit edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic uns,
                         input int exp_stalls, input string tag);
        exp_t e;
        int   st;
        logic mis;
        in_valid = 1; alu_result = a; write_data = d; mem_read = rd; mem_write = wr;
        mem_size = sz; mem_unsigned = uns; write_reg = a[4:0] ^ 5'd9; wb_ctrl = 2'b01;
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        e.alu = a; e.wr = a[4:0] ^ 5'd9; e.mis = mis; e.wb = mis ? 2'b00 : 2'b01; e.rd = 32'd0;
        if (!mis) begin
            if (wr) model_store(a, d, sz);
            else if (rd) e.rd = model_load(a, sz, uns);
        end
        sb.push_back(e);
        st = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!stall) break;
            st++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        clear_inputs();
        check({tag, "_stalls"}, st, exp_stalls);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
        rst = 1; clear_inputs();
        alu_result = 0; write_data = 0; write_reg = 0; wb_ctrl = 0; mem_size = 0; mem_unsigned = 0;
        in_valid_z = 0; mem_read_z = 0; mem_write_z = 0; alu_result_z = 0; write_data_z = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        check("rst_alu_out", alu_result_out, 32'd0);
        check("rst_wb_ctrl", {30'd0, wb_ctrl_out}, 32'd0);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        rst = 0;
        @(posedge clk); #1;

        do_op(32'h04, 32'h12345678, 0, 1, 2'b10, 0, 2, "st_w04");
        do_op(32'h04, 32'h0,        1, 0, 2'b10, 0, 2, "ld_w04");
        do_op(32'h05, 32'h000000AB, 0, 1, 2'b00, 0, 2, "st_b05");
        do_op(32'h05, 32'h0,        1, 0, 2'b00, 0, 2, "ld_bs05");
        do_op(32'h05, 32'h0,        1, 0, 2'b00, 1, 2, "ld_bu05");
        do_op(32'h04, 32'h0,        1, 0, 2'b10, 0, 2, "ld_w04b");
        do_op(32'h06, 32'h00008001, 0, 1, 2'b01, 0, 2, "st_h06");
        do_op(32'h06, 32'h0,        1, 0, 2'b01, 0, 2, "ld_hs06");
        do_op(32'h05, 32'h0,        1, 0, 2'b01, 0, 0, "ld_h05_mis");
        do_op(32'h04, 32'h0,        1, 0, 2'b10, 0, 2, "ld_w04c");
        do_op(32'h08, 32'hA5A5A5A5, 1, 1, 2'b10, 0, 2, "rdwr_08");
        do_op(32'h08, 32'h0,        1, 0, 2'b11, 0, 2, "ld_w08");
        check("literal_04", model_mem[1], 32'h8001AB78);

        // Branch pass-through, then flushed branch.
        in_valid = 1; branch = 1; zero = 1; alu_result = 32'h40; write_reg = 5'd0; wb_ctrl = 2'b10;
        begin
            exp_t e;
            e.rd = 0; e.alu = 32'h40; e.wr = 5'd0; e.wb = 2'b10; e.mis = 0;
            sb.push_back(e);
        end
        #1;
        check("pc_src_taken", {31'd0, pc_src}, 32'd1);
        check("branch_no_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1; #1;
        check("pc_src_flushed", {31'd0, pc_src}, 32'd0);
        @(posedge clk); #1;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        clear_inputs();

        // Store to 0x10 aborted by flush on the second stall cycle.
        in_valid = 1; mem_write = 1; mem_size = 2'b10; alu_result = 32'h10; write_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        flush = 1; #1;
        check("flush_stall_drop", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        check("flush_bubble", {31'd0, out_valid}, 32'd0);
        check("flush_mis", {31'd0, misaligned}, 32'd0);
        clear_inputs();
        do_op(32'h10, 32'h0, 1, 0, 2'b10, 0, 2, "ld_w10");

        // Store to 0x20 cut short by rst while waiting.
        in_valid = 1; mem_write = 1; mem_size = 2'b10; alu_result = 32'h20; write_data = 32'hFEEDFACE;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; clear_inputs(); #1;
        check("rstw_stall", {31'd0, stall}, 32'd0);
        check("rstw_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstw_alu_out", alu_result_out, 32'd0);
        check("rstw_read_data", read_data, 32'd0);
        check("rstw_wb_ctrl", {30'd0, wb_ctrl_out}, 32'd0);
        @(posedge clk); #1;
        do_op(32'h20, 32'h0, 1, 0, 2'b10, 0, 2, "ld_w20");

        do_op(32'h404, 32'hCAFEF00D, 0, 1, 2'b10, 0, 2, "st_alias");
        do_op(32'h004, 32'h0,        1, 0, 2'b10, 0, 2, "ld_alias");
        check("alias_model", model_mem[1], 32'hCAFEF00D);

        // Zero-latency instance: back-to-back store then load.
        in_valid_z = 1; mem_write_z = 1; alu_result_z = 32'h0C; write_data_z = 32'h55AA55AA;
        @(negedge clk);
        check("z_store_stall", {31'd0, stall_z}, 32'd0);
        @(posedge clk); #1;
        check("z_store_valid", {31'd0, out_valid_z}, 32'd1);
        mem_write_z = 0; mem_read_z = 1;
        @(negedge clk);
        check("z_load_stall", {31'd0, stall_z}, 32'd0);
        @(posedge clk); #1;
        check("z_load_valid", {31'd0, out_valid_z}, 32'd1);
        check("z_load_data", read_data_z, 32'h55AA55AA);
        in_valid_z = 0; mem_read_z = 0;

        repeat (3) @(posedge clk);
        #2;
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
